// File: rtl/dmem_responder_if.sv
// M-stage data-memory bus between the pipelined core (master) and dmem_responder (slave).
interface dmem_responder_if;
  logic        MemWriteM;
  logic [31:0] ALUResultM;
  logic [31:0] WriteData;
  logic [1:0]  StoreType;
  logic [31:0] ReadDataM;

  modport master (
    output MemWriteM,
    output ALUResultM,
    output WriteData,
    output StoreType,
    input  ReadDataM
  );

  modport slave (
    input  MemWriteM,
    input  ALUResultM,
    input  WriteData,
    input  StoreType,
    output ReadDataM
  );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory target for the core M-stage: combinational word reads, lane-masked stores,
// sticky misaligned-store flag. `define DMEM_MMIO_EN adds the TOHOST/CYCLE/STORECNT window.
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] MMIO_BASE   = 32'h1000_0000
) (
  input  logic              clk,
  input  logic              reset,
  dmem_responder_if.slave   bus,
  output logic              done,
  output logic [31:0]       tohost,
  output logic              misalign_err,
  output logic [31:0]       err_addr
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {
    ST_WORD = 2'b00,
    ST_HALF = 2'b01,
    ST_BYTE = 2'b10,
    ST_RSVD = 2'b11
  } storeType_e;

  logic [31:0]   mem [DEPTH_WORDS];
  logic [AW-1:0] wordIdx;
  logic [1:0]    byteOff;
  storeType_e    sType;
  logic          misaligned;
  logic          misStore;
  logic          commit;
  logic [3:0]    laneMask;
  logic [31:0]   laneData;
  logic [31:0]   ramWord;
  logic          mmioHit;
  logic          unusedAddrBits;

  assign wordIdx        = bus.ALUResultM[AW+1:2];
  assign byteOff        = bus.ALUResultM[1:0];
  assign ramWord        = mem[wordIdx];
  assign unusedAddrBits = ^bus.ALUResultM[31:AW+2];

  // Store data is replicated across lanes so the mask alone selects the target bytes.
  always_comb begin
    sType      = storeType_e'(bus.StoreType);
    laneMask   = '0;
    laneData   = bus.WriteData;
    misaligned = 1'b0;
    case (sType)
      ST_WORD: begin
        misaligned = (byteOff != 2'b00);
        laneMask   = 4'b1111;
      end
      ST_HALF: begin
        misaligned = byteOff[0];
        laneMask   = byteOff[1] ? 4'b1100 : 4'b0011;
        laneData   = {2{bus.WriteData[15:0]}};
      end
      ST_BYTE: begin
        laneMask   = 4'b0001 << byteOff;
        laneData   = {4{bus.WriteData[7:0]}};
      end
      default: laneMask = '0;
    endcase
    misStore = bus.MemWriteM && misaligned;
    commit   = bus.MemWriteM && !misaligned && (sType != ST_RSVD);
  end

  // RAM is never cleared; a store is only taken while out of reset.
  always_ff @(posedge clk) begin
    if (reset && commit && !mmioHit) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (laneMask[i]) mem[wordIdx][8*i +: 8] <= laneData[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      misalign_err <= 1'b0;
      err_addr     <= '0;
    end else if (misStore) begin
      misalign_err <= 1'b1;
      if (!misalign_err) err_addr <= bus.ALUResultM;
    end
  end

`ifdef DMEM_MMIO_EN
  typedef enum logic [1:0] {
    REG_TOHOST   = 2'b00,
    REG_CYCLE_LO = 2'b01,
    REG_CYCLE_HI = 2'b10,
    REG_STORECNT = 2'b11
  } mmioReg_e;

  logic [63:0] cycleCnt;
  logic [31:0] storeCnt;
  logic [31:0] mmioData;
  mmioReg_e    regSel;

  assign mmioHit = (bus.ALUResultM[31:4] == MMIO_BASE[31:4]);
  assign regSel  = mmioReg_e'(bus.ALUResultM[3:2]);

  // Stores to read-only registers are dropped but still counted as committed.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cycleCnt <= '0;
      storeCnt <= '0;
      done     <= 1'b0;
      tohost   <= '0;
    end else begin
      cycleCnt <= cycleCnt + 64'd1;
      if (commit) storeCnt <= storeCnt + 32'd1;
      if (commit && mmioHit && (regSel == REG_TOHOST)) begin
        done <= 1'b1;
        for (int unsigned i = 0; i < 4; i++) begin
          if (laneMask[i]) tohost[8*i +: 8] <= laneData[8*i +: 8];
        end
      end
    end
  end

  always_comb begin
    mmioData = '0;
    case (regSel)
      REG_TOHOST:   mmioData = tohost;
      REG_CYCLE_LO: mmioData = cycleCnt[31:0];
      REG_CYCLE_HI: mmioData = cycleCnt[63:32];
      REG_STORECNT: mmioData = storeCnt;
      default:      mmioData = '0;
    endcase
  end

  always_comb begin
    bus.ReadDataM = '0;
    if (reset) bus.ReadDataM = mmioHit ? mmioData : ramWord;
  end
`else
  assign mmioHit = 1'b0;
  assign done    = 1'b0;
  assign tohost  = '0;

  always_comb begin
    bus.ReadDataM = '0;
    if (reset) bus.ReadDataM = ramWord;
  end
`endif

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory target for the pipelined core's M-stage port.
- Accepts the core's MemWriteM / ALUResultM / WriteData / StoreType and returns ReadDataM in the same cycle; the core does load-lane extraction itself.
- Stores are performed with byte/half/word lane masking, misaligned stores are suppressed and flagged, and a small MMIO window provides test-exit and counter registers.

Parameters:
- DEPTH_WORDS, 1024: RAM depth in 32-bit words; must be a power of two.
- MMIO_BASE, 32'h1000_0000: base of the 16-byte MMIO window; must be 16-byte aligned.

Ports:
- clk  input  1  core clock.
- reset  input  1  asynchronous, active-low reset.
- MemWriteM  input  1  store strobe; one store per cycle while high.
- ALUResultM  input  32  byte address for the load or store.
- WriteData  input  32  store value, right-justified and unshifted.
- StoreType  input  2  store size: 00 word, 01 half, 10 byte, 11 reserved (no write).
- ReadDataM  output  32  full aligned word at ALUResultM[31:2], combinational.
- done  output  1  sticky; set by a write to TOHOST.
- tohost  output  32  last value written to TOHOST.
- misalign_err  output  1  sticky misaligned-store flag.
- err_addr  output  32  address of the first misaligned store.

Behaviour:
- Reset (reset==0, async):
  - done=0, tohost=0, misalign_err=0, err_addr=0.
  - cycle counter and store counter = 0.
  - ReadDataM forced to 0.
  - RAM contents are not cleared.
- Address decode:
  - MMIO hit when ALUResultM[31:4] == MMIO_BASE[31:4].
  - Otherwise RAM word index = ALUResultM[log2(DEPTH_WORDS)+1:2]; upper bits are ignored, so addresses alias modulo the depth.
- Reads:
  - Combinational, zero latency; ReadDataM is valid in the same cycle as the address.
  - Read-during-write returns the old word; the new data is visible from the next cycle.
- Stores, committed on posedge clk when MemWriteM=1:
  - word: requires ALUResultM[1:0]==00; all 4 lanes written.
  - half: requires ALUResultM[0]==0; WriteData[15:0] goes to lanes {a1+1, a1}, where a1 = ALUResultM[1]*2.
  - byte: WriteData[7:0] goes to lane ALUResultM[1:0].
  - Unselected lanes are preserved.
  - StoreType 11: no write, no error.
- Misaligned store (word with addr[1:0]!=0, or half with addr[0]=1):
  - Write suppressed; misalign_err set.
  - err_addr captured only on the first error; it holds until reset.
- Store counter:
  - Increments on each committed (non-suppressed, non-reserved) store, to RAM or MMIO.
  - 32-bit, wraps 0xFFFF_FFFF -> 0.
- Cycle counter:
  - 64-bit, increments every clk edge while reset is deasserted.
  - Wraps to 0 with no flag.
- Simultaneous events:
  - A store and a TOHOST write in the same cycle cannot occur; there is one port.
  - A store in the cycle reset deasserts is committed normally.
  - Reset asserted mid-store: the write is not guaranteed.

Optional Feature:
- Macro: DMEM_MMIO_EN.
- Defined, MMIO map at MMIO_BASE+:
  - 0x0 TOHOST, R/W: a word store latches tohost and sets done. Sub-word stores update the addressed lanes of tohost and also set done.
  - 0x4 CYCLE_LO, RO.
  - 0x8 CYCLE_HI, RO.
  - 0xC STORECNT, RO.
  - Writes to RO registers are dropped but still counted.
  - MMIO accesses never touch RAM.
- Not defined:
  - No MMIO decode; the window aliases into RAM.
  - done=0 and tohost=0 constantly.
  - Cycle and store counters are removed.

Test Plan:
- Word store then load: sw 0xDEADBEEF @0x40, then read 0x40 -> ReadDataM=0xDEADBEEF; read-during-write in the store cycle returns the prior value.
- Byte lanes: sw 0x11223344 @0x80, sb 0xAA @0x82 -> word 0x11AA3344. Then sh 0xBEEF @0x80 -> word 0x11AABEEF.
- Misaligned: sw @0x101 -> RAM unchanged, misalign_err=1, err_addr=0x101. Then sh @0x203 -> err_addr stays 0x101, store counter unchanged.
- Aliasing (DEPTH_WORDS=1024): sw 0x5 @0x0000_1000 -> read @0x0 returns 0x5.
- MMIO (DMEM_MMIO_EN): after reset, read CYCLE_LO at cycle N -> N-1 ± 0 per bench reference. Then sw 1 @MMIO_BASE -> done=1, tohost=1, STORECNT increments.
- Async reset mid-run: pull reset low between edges -> done, misalign_err, err_addr and counters clear immediately, ReadDataM=0; a RAM word written before reset reads back unchanged after release.
